// File: rtl/img_lut_mc.sv
// Multi-channel double-buffered pixel LUT for the AXI4-Stream video path.
// Each component has an active bank (read by video) and a shadow bank
// (written by the host). The banks swap only on an accepted start-of-frame
// beat, so a frame is never remapped through a mix of two curves.
module img_lut_mc #(
  parameter int unsigned PX_WIDTH  = 10,
  parameter int unsigned CHANNELS  = 3,
  parameter string       INIT_FILE = ""
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic [((CHANNELS*PX_WIDTH+7)/8)*8-1:0]             s_tdata_i,
  input  logic                                               s_tvalid_i,
  output logic                                               s_tready_o,
  input  logic                                               s_tuser_i,
  input  logic                                               s_tlast_i,
  output logic [((CHANNELS*PX_WIDTH+7)/8)*8-1:0]             m_tdata_o,
  output logic                                               m_tvalid_o,
  input  logic                                               m_tready_i,
  output logic                                               m_tuser_o,
  output logic                                               m_tlast_o,
  input  logic                                               wr_stb_i,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0]   wr_ch_i,
  input  logic [PX_WIDTH-1:0]                                wr_addr_i,
  input  logic [PX_WIDTH-1:0]                                wr_data_i,
  input  logic                                               swap_req_i,
  input  logic                                               bypass_i,
  output logic                                               swap_pending_o,
  output logic                                               active_bank_o
);

  localparam int unsigned TDATA_W = ((CHANNELS*PX_WIDTH+7)/8)*8;
  localparam int unsigned PIX_W   = CHANNELS*PX_WIDTH;
  localparam int unsigned DEPTH   = 2**PX_WIDTH;
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef logic [DEPTH-1:0][PX_WIDTH-1:0] table_t;

  typedef enum logic {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_e;

  // Power-up table image: identity.
  function automatic table_t init_table();
    table_t t;
    for (int unsigned i = 0; i < DEPTH; i++) t[i] = PX_WIDTH'(i);
    return t;
  endfunction

  swap_state_e          swap_state_q, swap_state_d;
  logic                 active_bank_q, active_bank_d;
  logic                 bypass_q, bypass_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic                 m_tuser_q, m_tuser_d;
  logic                 m_tlast_q, m_tlast_d;
  logic [TDATA_W-1:0]   m_tdata_q, m_tdata_d;

  logic                 ren;
  logic                 sof_acc;
  logic                 swap_pending;
  logic                 swap_now;
  logic                 rd_bank;
  logic                 byp_eff;
  logic [PIX_W-1:0]     lut_rd;

  // Read enable doubles as input ready so the output holds while stalled.
  assign ren        = !m_tvalid_q || m_tready_i;
  assign sof_acc    = s_tvalid_i && ren && s_tuser_i;
  // A swap taking effect on this beat already steers the read to the new bank.
  assign rd_bank    = active_bank_q ^ swap_now;
  // Bypass is sampled on the SOF beat itself and then held for the frame.
  assign byp_eff    = sof_acc ? bypass_i : bypass_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    table_t              bank0_q = init_table();
    table_t              bank1_q = init_table();
    logic                wr_hit;
    logic [PX_WIDTH-1:0] pix_addr;

    assign wr_hit   = wr_stb_i && (wr_ch_i == CH_W'(c));
    assign pix_addr = s_tdata_i[c*PX_WIDTH +: PX_WIDTH];

    // Host writes always land in the bank video is not reading.
    always_ff @(posedge clk_i) begin
      if (wr_hit && active_bank_q)  bank0_q[wr_addr_i] <= wr_data_i;
      if (wr_hit && !active_bank_q) bank1_q[wr_addr_i] <= wr_data_i;
    end

    assign lut_rd[c*PX_WIDTH +: PX_WIDTH] = rd_bank ? bank1_q[pix_addr] : bank0_q[pix_addr];
  end

  if (TDATA_W > PIX_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^s_tdata_i[TDATA_W-1:PIX_W];
  end

  // Swap FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) swap_state_q <= SWAP_IDLE;
    else       swap_state_q <= swap_state_d;
  end

  // Swap FSM next state: a request waits for the next accepted SOF beat.
  always_comb begin
    swap_state_d = swap_state_q;
    case (swap_state_q)
      SWAP_IDLE:    if (swap_req_i && !sof_acc) swap_state_d = SWAP_PENDING;
      SWAP_PENDING: if (sof_acc)                swap_state_d = SWAP_IDLE;
      default:                                  swap_state_d = SWAP_IDLE;
    endcase
  end

  // Swap FSM outputs; a request coincident with SOF applies on that beat.
  always_comb begin
    swap_pending = (swap_state_q == SWAP_PENDING);
    swap_now     = sof_acc && (swap_pending || swap_req_i);
  end

  // Next-state for the output stage, bank select and bypass latch.
  always_comb begin
    active_bank_d = active_bank_q ^ swap_now;
    bypass_d      = byp_eff;
    m_tvalid_d    = m_tvalid_q;
    m_tuser_d     = m_tuser_q;
    m_tlast_d     = m_tlast_q;
    m_tdata_d     = m_tdata_q;
    if (ren) begin
      m_tvalid_d             = s_tvalid_i;
      m_tuser_d              = s_tuser_i;
      m_tlast_d              = s_tlast_i;
      m_tdata_d              = '0;
      m_tdata_d[PIX_W-1:0]   = byp_eff ? s_tdata_i[PIX_W-1:0] : lut_rd;
    end
  end

  // Output stage and control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_bank_q <= 1'b0;
      bypass_q      <= 1'b0;
      m_tvalid_q    <= 1'b0;
      m_tuser_q     <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tdata_q     <= '0;
    end else begin
      active_bank_q <= active_bank_d;
      bypass_q      <= bypass_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tuser_q     <= m_tuser_d;
      m_tlast_q     <= m_tlast_d;
      m_tdata_q     <= m_tdata_d;
    end
  end

  assign s_tready_o     = ren;
  assign m_tdata_o      = m_tdata_q;
  assign m_tvalid_o     = m_tvalid_q;
  assign m_tuser_o      = m_tuser_q;
  assign m_tlast_o      = m_tlast_q;
  assign swap_pending_o = swap_pending;
  assign active_bank_o  = active_bank_q;

endmodule

// File: tb/tb_img_lut_mc.sv
// Bench for img_lut_mc: randomized streams and host writes checked against a
// table/queue reference model of the double-buffered LUT.
module tb_img_lut_mc;

  localparam int PXW = 10;
  localparam int CH  = 3;
  localparam int TW  = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [TW-1:0] s_tdata_i;
  logic          s_tvalid_i;
  logic          s_tready_o;
  logic          s_tuser_i;
  logic          s_tlast_i;
  logic [TW-1:0] m_tdata_o;
  logic          m_tvalid_o;
  logic          m_tready_i;
  logic          m_tuser_o;
  logic          m_tlast_o;
  logic          wr_stb_i;
  logic [1:0]    wr_ch_i;
  logic [PXW-1:0] wr_addr_i;
  logic [PXW-1:0] wr_data_i;
  logic          swap_req_i;
  logic          bypass_i;
  logic          swap_pending_o;
  logic          active_bank_o;

  always #5 clk_i = ~clk_i;

  img_lut_mc #(.PX_WIDTH(PXW), .CHANNELS(CH), .INIT_FILE("")) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
    .s_tuser_i(s_tuser_i), .s_tlast_i(s_tlast_i),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
    .m_tuser_o(m_tuser_o), .m_tlast_o(m_tlast_o),
    .wr_stb_i(wr_stb_i), .wr_ch_i(wr_ch_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .swap_req_i(swap_req_i), .bypass_i(bypass_i),
    .swap_pending_o(swap_pending_o), .active_bank_o(active_bank_o)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: two tables per channel, bank/pending/bypass flags and a
  // queue of beats the DUT still owes on its output.
  typedef struct {
    logic [TW-1:0] data;
    bit            user;
    bit            last;
  } beat_t;

  int unsigned tbl [CH][2][1024];
  bit          m_bank, m_pend, m_byp;
  beat_t       exp_q[$];
  bit          rand_rdy = 1'b0;
  bit          acc_flag;

  function automatic logic [TW-1:0] pack3(input int unsigned a, input int unsigned b, input int unsigned c);
    logic [TW-1:0] v;
    v = '0;
    v[0 +: PXW]     = PXW'(a);
    v[PXW +: PXW]   = PXW'(b);
    v[2*PXW +: PXW] = PXW'(c);
    return v;
  endfunction

  // One clock: check outputs at mid-cycle, advance the model by the edge's events.
  task automatic tick();
    bit            acc_in, acc_out, old_shadow;
    beat_t         b;
    logic [PXW-1:0] pix;
    if (rand_rdy) m_tready_i = 1'($urandom_range(0, 1));
    #1;
    check_eq("active_bank", active_bank_o, m_bank);
    check_eq("swap_pending", swap_pending_o, m_pend);
    check_eq("s_tready", s_tready_o, (!m_tvalid_o) || m_tready_i);
    if (m_tvalid_o) begin
      if (exp_q.size() == 0) check_eq("extra_beat", m_tvalid_o, 0);
      else begin
        check_eq("tdata", m_tdata_o, exp_q[0].data);
        check_eq("tuser", m_tuser_o, exp_q[0].user);
        check_eq("tlast", m_tlast_o, exp_q[0].last);
      end
    end else begin
      check_eq("lost_beat", exp_q.size(), 0);
    end
    acc_in  = s_tvalid_i && s_tready_o;
    acc_out = m_tvalid_o && m_tready_i;
    if (acc_out && exp_q.size() > 0) void'(exp_q.pop_front());
    old_shadow = !m_bank;
    if (swap_req_i) m_pend = 1'b1;
    if (acc_in && s_tuser_i) begin
      if (m_pend) begin
        m_bank = !m_bank;
        m_pend = 1'b0;
      end
      m_byp = bypass_i;
    end
    if (acc_in) begin
      b.data = '0;
      for (int c = 0; c < CH; c++) begin
        pix = s_tdata_i[c*PXW +: PXW];
        b.data[c*PXW +: PXW] = m_byp ? pix : PXW'(tbl[c][m_bank][pix]);
      end
      b.user = s_tuser_i;
      b.last = s_tlast_i;
      exp_q.push_back(b);
    end
    if (wr_stb_i && wr_ch_i < CH) tbl[wr_ch_i][old_shadow][wr_addr_i] = wr_data_i;
    acc_flag = acc_in;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic send_beat(input logic [TW-1:0] d, input bit user, input bit last);
    s_tdata_i  = d;
    s_tuser_i  = user;
    s_tlast_i  = last;
    s_tvalid_i = 1'b1;
    acc_flag   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      swap_req_i = 1'b0;
      if (acc_flag) break;
    end
    check_eq("accept_timeout", acc_flag, 1);
    s_tvalid_i = 1'b0;
    s_tuser_i  = 1'b0;
    s_tlast_i  = 1'b0;
  endtask

  task automatic host_write(input int ch, input int unsigned addr, input int unsigned data);
    wr_stb_i  = 1'b1;
    wr_ch_i   = 2'(ch);
    wr_addr_i = PXW'(addr);
    wr_data_i = PXW'(data);
    tick();
    wr_stb_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    rand_rdy   = 1'b0;
    m_tready_i = 1'b1;
    idle(3);
  endtask

  initial begin
    rst_i = 1'b0; s_tdata_i = '0; s_tvalid_i = 1'b0; s_tuser_i = 1'b0; s_tlast_i = 1'b0;
    m_tready_i = 1'b1; wr_stb_i = 1'b0; wr_ch_i = '0; wr_addr_i = '0; wr_data_i = '0;
    swap_req_i = 1'b0; bypass_i = 1'b0;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < 2; k++)
        for (int a = 0; a < 1024; a++) tbl[c][k][a] = a;
    m_bank = 0; m_pend = 0; m_byp = 0;

    #2 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_eq("rst_tvalid", m_tvalid_o, 0);
    check_eq("rst_tuser", m_tuser_o, 0);
    check_eq("rst_tlast", m_tlast_o, 0);
    check_eq("rst_tdata", m_tdata_o, 0);
    check_eq("rst_pending", swap_pending_o, 0);
    check_eq("rst_bank", active_bank_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Identity stream of every table index.
    for (int i = 0; i < 1024; i++) send_beat(pack3(i, 1023 - i, i), i == 0, (i % 64) == 63);
    drain();

    // Shadow write is invisible until the swap, then lands on the SOF beat.
    host_write(1, 5, 10'h3FF);
    send_beat(pack3(5, 5, 5), 0, 0);
    check_eq("noswap_5", m_tdata_o, 32'h0050_1405);
    swap_req_i = 1'b1;
    tick();
    swap_req_i = 1'b0;
    check_eq("pend_after_req", swap_pending_o, 1);
    send_beat(pack3(5, 5, 5), 1, 0);
    check_eq("swap_5", m_tdata_o, 32'h005F_FC05);
    check_eq("swap_bank", active_bank_o, 1);
    check_eq("swap_pend_fall", swap_pending_o, 0);
    drain();

    // Swap requested mid-frame only takes effect at the next SOF.
    host_write(0, 7, 10'h123);
    send_beat(pack3(7, 7, 7), 1, 0);
    send_beat(pack3(7, 7, 7), 0, 0);
    swap_req_i = 1'b1;
    send_beat(pack3(7, 7, 7), 0, 0);
    swap_req_i = 1'b1;
    send_beat(pack3(7, 7, 7), 0, 1);
    check_eq("mid_old_bank", m_tdata_o, pack3(7, 7, 7));
    send_beat(pack3(7, 7, 7), 1, 0);
    check_eq("mid_new_bank", m_tdata_o, pack3(10'h123, 7, 7));
    drain();

    // Random curve, swap coincident with SOF, 64x4 frame under 50% stall.
    for (int i = 0; i < 32; i++) host_write($urandom_range(0, 2), $urandom_range(0, 1023), $urandom_range(0, 1023));
    rand_rdy = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 0) swap_req_i = 1'b1;
      send_beat(pack3($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023)),
                i == 0, (i % 64) == 63);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(20);
    drain();

    // Bypass only changes at SOF boundaries.
    bypass_i = 1'b0;
    send_beat(pack3(5, 5, 7), 1, 0);
    bypass_i = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(pack3(5, $urandom_range(0, 1023), 7), 0, i == 3);
    send_beat(pack3(5, 5, 7), 1, 0);
    check_eq("bypass_sof", m_tdata_o, pack3(5, 5, 7));
    bypass_i = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(pack3(5, $urandom_range(0, 1023), 7), 0, i == 3);
    send_beat(pack3(5, 5, 7), 1, 0);
    drain();

    // Writes to a nonexistent channel change nothing.
    host_write(3, 5, 10'h0AA);
    host_write(3, 7, 10'h0AA);
    swap_req_i = 1'b1;
    send_beat(pack3(5, 5, 5), 1, 0);
    send_beat(pack3(7, 7, 7), 0, 1);
    drain();

    // Reset while a swap is pending and an output beat is stalled.
    if (!m_bank) begin
      swap_req_i = 1'b1;
      send_beat(pack3(1, 2, 3), 1, 0);
      drain();
    end
    swap_req_i = 1'b1;
    tick();
    swap_req_i = 1'b0;
    m_tready_i = 1'b0;
    send_beat(pack3(9, 9, 9), 0, 0);
    check_eq("pre_rst_valid", m_tvalid_o, 1);
    check_eq("pre_rst_bank", active_bank_o, 1);
    rst_i = 1'b1;
    #1;
    check_eq("rst_mid_tvalid", m_tvalid_o, 0);
    check_eq("rst_mid_pending", swap_pending_o, 0);
    check_eq("rst_mid_bank", active_bank_o, 0);
    exp_q.delete();
    m_pend = 0; m_bank = 0; m_byp = 0;
    @(negedge clk_i);
    m_tready_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++)
      send_beat(pack3($urandom_range(0, 1023), 5, 7), i == 0, i == 7);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
